// File: rtl/lab62_onchip_mem_master.sv
// Avalon-MM master sequencer for the single-port on-chip RAM (read latency 1).
// Handles one fill or read command at a time. Reads stream out through a
// 2-entry buffer whose read issue is credit-limited, so backpressure never
// overflows it.
//
// Handshake semantics (both ports): a transfer happens on the rising clk edge
// where valid and ready are both 1; valid, once raised, holds its payload
// until that edge.
module lab62_onchip_mem_master #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [ADDR_W:0]       cmd_len,
    input  logic [DATA_W-1:0]     cmd_data,
    input  logic                  cmd_incr,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    input  logic [DATA_W-1:0]     avm_readdata,
    output logic                  avm_clken,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_READ   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   LEN_ZERO = '0;
    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [DATA_W-1:0] DATA_ONE = 1;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_rem;
    logic [DATA_W-1:0]   r_pat;
    logic                r_incr;
    logic [1:0]          r_occ;
    logic                r_inflight;
    logic [DATA_W-1:0]   r_buf0;
    logic [DATA_W-1:0]   r_buf1;

    logic                w_is_fill;
    logic                w_issue;
    logic [1:0]          w_cnt;
    logic [1:0]          w_occ_nxt;
    logic                w_pop;
    logic [DATA_W-1:0]   w_e0;
    logic [DATA_W-1:0]   w_e1;

    // Bus and stream decode. The word returning from the RAM (its registered
    // q, one cycle after issue) counts as a buffer entry in the cycle it
    // arrives, so it can be presented and consumed immediately.
    always_comb begin
        w_is_fill = (r_state == S_FILL);
        w_cnt     = r_occ + {1'b0, r_inflight};
        w_issue   = (r_state == S_READ) && (r_rem != LEN_ZERO) && (w_cnt < 2'd2);
        w_e0      = (r_occ != 2'd0) ? r_buf0 : avm_readdata;
        w_e1      = (r_occ == 2'd2) ? r_buf1 : avm_readdata;
        w_pop     = (w_cnt != 2'd0) && rd_ready;
        w_occ_nxt = w_pop ? (w_cnt - 2'd1) : w_cnt;
    end

    assign cmd_ready      = (r_state == S_IDLE);
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_FINISH);
    assign avm_chipselect = w_is_fill | w_issue;
    assign avm_write      = w_is_fill;
    assign avm_address    = r_addr;
    assign avm_writedata  = r_pat;
    assign avm_byteenable = avm_chipselect ? '1 : '0;
    assign avm_clken      = 1'b1;
    assign rd_valid       = (w_cnt != 2'd0);
    assign rd_data        = rd_valid ? w_e0 : '0;

    // Command sequencer: latches the command, walks address/pattern/count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_pat   <= '0;
            r_incr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr <= cmd_addr;
                        r_rem  <= cmd_len;
                        r_pat  <= cmd_data;
                        r_incr <= cmd_incr;
                        if (cmd_len == LEN_ZERO) r_state <= S_FINISH;
                        else if (cmd_op)         r_state <= S_READ;
                        else                     r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_addr <= r_addr + ADDR_ONE;
                    r_rem  <= r_rem - LEN_ONE;
                    if (r_incr) r_pat <= r_pat + DATA_ONE;
                    if (r_rem == LEN_ONE) r_state <= S_FINISH;
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr <= r_addr + ADDR_ONE;
                        r_rem  <= r_rem - LEN_ONE;
                    end
                    // Nothing left to issue and the buffer drains this edge.
                    if ((r_rem == LEN_ZERO) && (w_occ_nxt == 2'd0)) r_state <= S_FINISH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output buffer: absorb the returning word, pop on handshake, keep order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_issue;
            r_occ      <= w_occ_nxt;
            if (w_pop) begin
                r_buf0 <= w_e1;
            end else begin
                r_buf0 <= w_e0;
                r_buf1 <= w_e1;
            end
        end
    end

endmodule
